data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the number of 32-bit words stored (power of two, 4..1024).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the cycles from request acceptance to response (range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port mem_req, input, 1 bit: access request from the pipeline MEM stage.
REQ-006 The block SHALL have port mem_we, input, 1 bit: 1 = write, 0 = read; sampled with mem_req.
REQ-007 The block SHALL have port mem_addr, input, 32 bits: byte address, word-aligned.
REQ-008 The block SHALL have port mem_wdata, input, 32 bits: write data.
REQ-009 The block SHALL have port mem_rdata, output, 32 bits: registered response data.
REQ-010 The block SHALL have port mem_ready, output, 1 bit: one-cycle response pulse.
REQ-011 The block SHALL have port mem_stall, output, 1 bit: freeze request to the pipeline.
REQ-012 The block SHALL have port mem_err, output, 1 bit: error flag, valid only while mem_ready=1.

Function
REQ-013 The block SHALL implement states IDLE, BUSY and RESP with a 4-bit latency counter.
REQ-014 In IDLE, mem_req=1 at a rising edge SHALL be accepted: capture mem_we, mem_addr and mem_wdata; load counter=LATENCY; go to BUSY.
REQ-015 In BUSY, the block SHALL go to RESP at the edge where counter==1; otherwise it SHALL decrement the counter.
REQ-016 RESP SHALL last exactly one cycle, return to IDLE, and ignore mem_req during that cycle.
REQ-017 mem_ready SHALL be 1 only in RESP, i.e. the cycle following the LATENCY-th edge after acceptance.
REQ-018 mem_stall SHALL be combinational: 1 when (IDLE and mem_req=1) or BUSY; 0 in RESP; 0 while reset=0.
REQ-019 The word index SHALL be mem_addr[log2(DEPTH)+1:2].
REQ-020 An access SHALL be in error when mem_addr[1:0]!=0 or mem_addr[31:2]>=DEPTH.
REQ-021 A non-error write SHALL commit to the array at the RESP-entry edge.
REQ-022 For a write, mem_rdata SHALL be 0 in RESP.
REQ-023 For a non-error read, mem_rdata SHALL load the addressed word at the RESP-entry edge.
REQ-024 An error access SHALL give mem_err=1 with mem_ready, no array write, and mem_rdata=0.
REQ-025 mem_rdata SHALL hold its value until the next RESP entry.
REQ-026 mem_err SHALL be 0 outside RESP.
REQ-027 Throughput SHALL be one access per LATENCY+2 cycles with mem_req held high.

Reset
REQ-028 While reset=0 at a rising edge: state=IDLE, counter=0, mem_rdata=0, mem_ready=0, mem_err=0.
REQ-029 Reset asserted in BUSY SHALL abort the access with no write committed and no response.
REQ-030 Array contents SHALL NOT be altered by reset; contents after power-up are undefined.

Verification (DEPTH=64, LATENCY=2 unless noted)
REQ-031 reset=0 for 2 cycles with mem_req=1 -> mem_stall=0, mem_ready=0, mem_err=0, mem_rdata=0; after release, request accepted at first edge.
REQ-032 Write 0xDEADBEEF @0x10, then read @0x10 -> each: mem_stall high 3 cycles, mem_ready one pulse 2 edges after acceptance; read gives mem_rdata=0xDEADBEEF, mem_err=0.
REQ-033 Write @0x13 -> mem_err=1 with mem_ready, mem_rdata=0; subsequent read @0x10 still returns 0xDEADBEEF.
REQ-034 Read @0x100 (index 64) -> mem_err=1, mem_rdata=0.
REQ-035 Write 0x12345678 @0x20; start write 0xFFFFFFFF @0x20 and pulse reset=0 in BUSY -> no mem_ready; read @0x20 returns 0x12345678.
REQ-036 LATENCY=1, mem_req held high with reads @0x0 -> mem_ready pulses every 3 cycles, stall pattern 1,1,0 repeating.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory for the pipeline MEM stage. Each access is answered
// with a one-cycle ready pulse a fixed LATENCY after acceptance.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    count;
  logic          we_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH];

  logic          req_err;
  logic          accept;
  logic          resp_entry;

  assign req_err    = (mem_addr[1:0] != 2'b00) || (mem_addr[31:2] >= 30'(DEPTH));
  assign accept     = (state == IDLE) && mem_req;
  assign resp_entry = (state == BUSY) && (count == 4'd1);

  assign mem_ready = (state == RESP);
  assign mem_stall = reset && (accept || (state == BUSY));

  // Request fields are only meaningful while BUSY, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= mem_we;
      err_q   <= req_err;
      idx_q   <= mem_addr[AW+1:2];
      wdata_q <= mem_wdata;
    end
  end

  // Array is never reset; a write pending when reset arrives is dropped.
  always_ff @(posedge clk) begin
    if (reset && resp_entry && we_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      mem_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            count <= 4'(LATENCY);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (count == 4'd1) begin
            state     <= RESP;
            mem_err   <= err_q;
            mem_rdata <= (we_q || err_q) ? '0 : mem[idx_q];
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          mem_err <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset/abort sequences,
// LATENCY=1 throughput check and randomized accesses against a word-array model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH0 = 64;
  localparam int unsigned LAT0   = 2;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_stall;
  logic        mem_err;

  logic        r1_reset;
  logic        r1_req;
  logic        r1_we;
  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic [31:0] r1_rdata;
  logic        r1_ready;
  logic        r1_stall;
  logic        r1_err;

  int unsigned tests;
  int unsigned failed;

  data_mem_responder #(.DEPTH(DEPTH0), .LATENCY(LAT0)) u0 (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_stall(mem_stall), .mem_err(mem_err)
  );

  data_mem_responder #(.DEPTH(64), .LATENCY(1)) u1 (
    .clk(clk), .reset(r1_reset), .mem_req(r1_req), .mem_we(r1_we),
    .mem_addr(r1_addr), .mem_wdata(r1_wdata), .mem_rdata(r1_rdata),
    .mem_ready(r1_ready), .mem_stall(r1_stall), .mem_err(r1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  logic [31:0] model [DEPTH0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one access from IDLE and follow it through to the cycle after RESP.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic chk_rd, input logic exp_err, input logic [31:0] exp_rd);
    int unsigned n;
    logic seen;
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wd;
    #1;
    check("stall_on_req", {31'b0, mem_stall}, 32'd1);
    step();
    mem_req   = 1'b0;
    mem_we    = ~we;
    mem_addr  = $urandom;
    mem_wdata = $urandom;
    #1;
    check("stall_busy0", {31'b0, mem_stall}, 32'd1);
    check("ready_busy0", {31'b0, mem_ready}, 32'd0);
    seen = 1'b0;
    n = 1;
    while (!seen && n < 20) begin
      step();
      if (mem_ready) seen = 1'b1;
      else begin
        n++;
        check("stall_busy", {31'b0, mem_stall}, 32'd1);
        check("err_busy", {31'b0, mem_err}, 32'd0);
      end
    end
    check("ready_latency", seen ? n : 32'd999, LAT0);
    check("stall_resp", {31'b0, mem_stall}, 32'd0);
    check("err_resp", {31'b0, mem_err}, {31'b0, exp_err});
    if (chk_rd) check("rdata_resp", mem_rdata, exp_rd);
    step();
    check("ready_after", {31'b0, mem_ready}, 32'd0);
    check("err_after", {31'b0, mem_err}, 32'd0);
    if (chk_rd) check("rdata_hold", mem_rdata, exp_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned addr_sel;
    int unsigned idx;
    logic        rwe;
    logic [31:0] raddr;
    logic [31:0] rwd;
    logic        eerr;
    logic [31:0] erd;

    tests  = 0;
    failed = 0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0013, 32'hCAFE_F00D, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hA5A5_A5A5};
    vecs[7]  = '{1'b0, 32'h0000_0002, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'h0000_0011, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0011};
    vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_0100, 32'h7777_7777, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0011};
    vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};

    // Reset held with a request pending: nothing may happen.
    reset     = 1'b0;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = 32'h10;
    mem_wdata = '0;
    r1_reset  = 1'b0;
    r1_req    = 1'b0;
    r1_we     = 1'b0;
    r1_addr   = '0;
    r1_wdata  = '0;
    #1;
    check("rst_stall_pre", {31'b0, mem_stall}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_stall", {31'b0, mem_stall}, 32'd0);
      check("rst_ready", {31'b0, mem_ready}, 32'd0);
      check("rst_err", {31'b0, mem_err}, 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
    end
    reset = 1'b1;

    // Directed table; first entry is accepted at the first edge after release.
    for (int i = 0; i < 14; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b1, vecs[i].exp_err, vecs[i].exp_rdata);
    end

    // Reset in BUSY aborts a pending write and clears the response registers.
    access(1'b1, 32'h20, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
    access(1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h20;
    mem_wdata = 32'hFFFF_FFFF;
    step();
    mem_req = 1'b0;
    #1;
    check("abort_stall_busy", {31'b0, mem_stall}, 32'd1);
    step();
    reset = 1'b0;
    #1;
    check("abort_stall_rst", {31'b0, mem_stall}, 32'd0);
    step();
    check("abort_ready", {31'b0, mem_ready}, 32'd0);
    check("abort_rdata", mem_rdata, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_no_ready", {31'b0, mem_ready}, 32'd0);
    end
    access(1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h1234_5678);

    // Randomized phase: fill every word, then mixed traffic against the model.
    for (int i = 0; i < 64; i++) begin
      model[i] = $urandom;
      access(1'b1, 32'(i) * 32'd4, model[i], 1'b1, 1'b0, 32'h0);
    end
    for (int k = 0; k < 200; k++) begin
      addr_sel = $urandom_range(0, 9);
      if (addr_sel < 7)       raddr = 32'($urandom_range(0, 63)) * 32'd4;
      else if (addr_sel == 7) raddr = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
      else if (addr_sel == 8) raddr = 32'($urandom_range(64, 1000)) * 32'd4;
      else                    raddr = $urandom;
      rwe  = 1'($urandom_range(0, 1));
      rwd  = $urandom;
      eerr = (raddr % 4 != 0) || (raddr / 4 >= DEPTH0);
      idx  = raddr / 4;
      if (eerr || rwe) erd = 32'h0;
      else             erd = model[idx];
      access(rwe, raddr, rwd, 1'b1, eerr, erd);
      if (rwe && !eerr) model[idx] = rwd;
      if ($urandom_range(0, 3) == 0) begin
        step();
        check("idle_stall", {31'b0, mem_stall}, 32'd0);
        check("idle_ready", {31'b0, mem_ready}, 32'd0);
      end
    end

    // LATENCY=1 with the request held: ready every third cycle, stall 1,1,0.
    r1_reset = 1'b1;
    r1_req   = 1'b1;
    r1_we    = 1'b0;
    r1_addr  = 32'h0;
    #1;
    for (int k = 0; k < 12; k++) begin
      check("l1_stall", {31'b0, r1_stall}, (k % 3 != 2) ? 32'd1 : 32'd0);
      check("l1_ready", {31'b0, r1_ready}, (k % 3 == 2) ? 32'd1 : 32'd0);
      check("l1_err", {31'b0, r1_err}, 32'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
